// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared SVGA timing defaults and sprite-controller state type
package vga_pkg;

  localparam int H_RES = 800;
  localparam int V_RES = 600;

  typedef enum logic [1:0] {IDLE, FALL, BOUNCE, STOP} rect_ctl_state_t;

endpackage

// File: rtl/edge_det.sv
// rtl/edge_det.sv - single-bit rising-edge detector, previous sample cleared by rst
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      din_q <= 1'b0;
    end else begin
      din_q <= din;
    end
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/draw_rect_ctl.sv
// rtl/draw_rect_ctl.sv - per-frame sprite position: mouse follow or gravity fall with decaying bounces
// Optional: DRAW_RECT_CTL_CLAMP_EN keeps the mouse-following sprite fully on screen.
module draw_rect_ctl
  import vga_pkg::*;
#(
  parameter int H_RES   = vga_pkg::H_RES,
  parameter int V_RES   = vga_pkg::V_RES,
  parameter int RECT_W  = 48,
  parameter int RECT_H  = 64,
  parameter int GRAVITY = 1,
  parameter int VMAX    = 40,
  parameter int VMIN    = 4
) (
  input  logic        clk40MHz,
  input  logic        rst,
  input  logic        vblnk,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        mouse_left,
  output logic [11:0] x_start,
  output logic [11:0] y_start,
  output logic        falling
);

  localparam logic [11:0] FLOOR = 12'(V_RES - RECT_H);
  localparam logic [11:0] X_MAX = 12'(H_RES - RECT_W);
  localparam logic [8:0]  GRAV9 = 9'(GRAVITY);
  localparam logic [8:0]  VMAX9 = 9'(VMAX);
  localparam logic [7:0]  GRAV8 = 8'(GRAVITY);
  localparam logic [7:0]  VMIN8 = 8'(VMIN);

  rect_ctl_state_t state;
  logic [7:0]      velocity;
  logic            tick;
  logic            press;

  edge_det u_tick_det (
    .clk  (clk40MHz),
    .rst  (rst),
    .din  (vblnk),
    .rise (tick)
  );

  edge_det u_press_det (
    .clk  (clk40MHz),
    .rst  (rst),
    .din  (mouse_left),
    .rise (press)
  );

  logic [8:0]  v_inc;
  logic [7:0]  v_fall;
  logic [12:0] y_sum;
  logic [9:0]  v_imp3;
  logic [7:0]  v_imp;
  logic [11:0] y_up;
  logic [11:0] idle_x;
  logic [11:0] idle_y;

  // Extra bit on the sums so neither the speed nor the position can wrap.
  always_comb begin
    v_inc  = {1'b0, velocity} + GRAV9;
    v_fall = (v_inc > VMAX9) ? VMAX9[7:0] : v_inc[7:0];
    y_sum  = {1'b0, y_start} + {5'd0, v_fall};
    v_imp3 = {2'b00, v_fall} + {1'b0, v_fall, 1'b0};
    v_imp  = v_imp3[9:2];
    y_up   = (y_start > {4'd0, velocity}) ? (y_start - {4'd0, velocity}) : 12'd0;
  end

`ifdef DRAW_RECT_CTL_CLAMP_EN
  assign idle_x = (mouse_xpos > X_MAX) ? X_MAX : mouse_xpos;
  assign idle_y = (mouse_ypos > FLOOR) ? FLOOR : mouse_ypos;
`else
  assign idle_x = mouse_xpos;
  assign idle_y = mouse_ypos;
`endif

  always_ff @(posedge clk40MHz) begin
    if (rst) begin
      state    <= IDLE;
      velocity <= 8'd0;
      x_start  <= 12'd0;
      y_start  <= 12'd0;
      falling  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A press in the same cycle as a tick takes priority over the position load.
          if (press) begin
            state    <= FALL;
            velocity <= 8'd0;
            falling  <= 1'b1;
          end else if (tick) begin
            x_start <= idle_x;
            y_start <= idle_y;
          end
        end
        FALL: begin
          if (tick) begin
            if (y_sum >= {1'b0, FLOOR}) begin
              y_start  <= FLOOR;
              velocity <= v_imp;
              if (v_imp < VMIN8) begin
                state   <= STOP;
                falling <= 1'b0;
              end else begin
                state <= BOUNCE;
              end
            end else begin
              y_start  <= y_sum[11:0];
              velocity <= v_fall;
            end
          end
        end
        BOUNCE: begin
          if (tick) begin
            y_start <= y_up;
            if (velocity <= GRAV8) begin
              velocity <= 8'd0;
              state    <= FALL;
            end else begin
              velocity <= velocity - GRAV8;
            end
          end
        end
        STOP: begin
          if (press) begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          falling <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_draw_rect_ctl.sv
// tb/tb_draw_rect_ctl.sv - scoreboard bench for draw_rect_ctl with directed frame/press vectors
module tb_draw_rect_ctl;
  import vga_pkg::*;

  logic        clk40MHz = 1'b0;
  logic        rst = 1'b1;
  logic        vblnk = 1'b0;
  logic        mouse_left = 1'b0;
  logic [11:0] mouse_xpos = 12'd0;
  logic [11:0] mouse_ypos = 12'd0;
  logic [11:0] x_start;
  logic [11:0] y_start;
  logic        falling;

  draw_rect_ctl dut (
    .clk40MHz   (clk40MHz),
    .rst        (rst),
    .vblnk      (vblnk),
    .mouse_xpos (mouse_xpos),
    .mouse_ypos (mouse_ypos),
    .mouse_left (mouse_left),
    .x_start    (x_start),
    .y_start    (y_start),
    .falling    (falling)
  );

  always #5 clk40MHz = ~clk40MHz;

  typedef struct {
    int    x;
    int    y;
    bit    f;
    string tag;
  } exp_t;

  exp_t            sb[$];
  logic            obs_valid = 1'b0;
  int              n_cmp = 0;
  int              n_bad = 0;

  rect_ctl_state_t m_st = IDLE;
  int              m_x = 0;
  int              m_y = 0;
  int              m_v = 0;

  always @(posedge clk40MHz) begin
    exp_t e;
    #1;
    if (obs_valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_empty: output observed with no expected entry");
      end else begin
        e = sb.pop_front();
        if (int'(x_start) != e.x || int'(y_start) != e.y || falling !== e.f) begin
          n_bad++;
          $display("FAIL %s: got x=%0d y=%0d falling=%0b, want x=%0d y=%0d falling=%0b",
                   e.tag, x_start, y_start, falling, e.x, e.y, e.f);
        end
      end
    end
  end

  task automatic model_tick();
    int v;
    int ny;
    case (m_st)
      IDLE: begin
        m_x = int'(mouse_xpos);
        m_y = int'(mouse_ypos);
`ifdef DRAW_RECT_CTL_CLAMP_EN
        if (m_x > 752) m_x = 752;
        if (m_y > 536) m_y = 536;
`endif
      end
      FALL: begin
        v = m_v + 1;
        if (v > 40) v = 40;
        ny = m_y + v;
        if (ny >= 536) begin
          m_y = 536;
          m_v = (v * 3) / 4;
          m_st = (m_v < 4) ? STOP : BOUNCE;
        end else begin
          m_y = ny;
          m_v = v;
        end
      end
      BOUNCE: begin
        m_y = (m_y > m_v) ? m_y - m_v : 0;
        if (m_v <= 1) begin
          m_v = 0;
          m_st = FALL;
        end else begin
          m_v = m_v - 1;
        end
      end
      default: ;
    endcase
  endtask

  // One stimulus cycle; hand_y >= 0 replaces the model's y with a hand-computed value.
  task automatic step(input bit t, input bit p, input string tag, input int hand_y);
    exp_t e;
    @(negedge clk40MHz);
    vblnk = t;
    mouse_left = p;
    if (p && m_st == IDLE) begin
      m_st = FALL;
      m_v = 0;
    end else if (p && m_st == STOP) begin
      m_st = IDLE;
    end else if (t) begin
      model_tick();
    end
    e.x = m_x;
    e.y = (hand_y >= 0) ? hand_y : m_y;
    e.f = (m_st == FALL || m_st == BOUNCE);
    e.tag = tag;
    sb.push_back(e);
    obs_valid = 1'b1;
    @(negedge clk40MHz);
    vblnk = 1'b0;
    mouse_left = 1'b0;
    obs_valid = 1'b0;
  endtask

  task automatic do_reset(input int ncyc, input string tag);
    exp_t e;
    @(negedge clk40MHz);
    rst = 1'b1;
    m_st = IDLE; m_x = 0; m_y = 0; m_v = 0;
    for (int i = 0; i < ncyc; i++) begin
      e.x = 0; e.y = 0; e.f = 1'b0; e.tag = tag;
      sb.push_back(e);
      obs_valid = 1'b1;
      @(negedge clk40MHz);
    end
    obs_valid = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    mouse_xpos = 12'd100;
    mouse_ypos = 12'd200;
    do_reset(2, "reset_state");
    step(1, 0, "follow_100_200", 200);

    mouse_ypos = 12'd0;
    step(1, 0, "follow_top", 0);
    step(0, 1, "press_idle", 0);
    for (int k = 1; k <= 32; k++) begin
      step(1, 0, $sformatf("fall_k%0d", k), k * (k + 1) / 2);
      if (k == 10) step(0, 1, "press_in_fall", 55);
    end
    step(1, 0, "impact_33", 536);
    step(1, 0, "bounce_1", 512);
    step(1, 0, "bounce_2", 489);
    for (int i = 0; i < 400 && m_st != STOP; i++) begin
      step(1, 0, "bounce_decay", -1);
    end
    for (int i = 0; i < 5; i++) begin
      step(1, 0, "stop_hold", 536);
    end

    mouse_xpos = 12'd300;
    mouse_ypos = 12'd400;
    step(0, 1, "press_stop", 536);
    step(1, 0, "idle_after_stop", 400);

    mouse_xpos = 12'd50;
    mouse_ypos = 12'd60;
    step(1, 1, "press_tick_same_cycle", 400);
    step(1, 0, "fall_after_collision", 401);
    for (int i = 0; i < 100 && m_st != BOUNCE; i++) begin
      step(1, 0, "fall_to_bounce", -1);
    end
    step(1, 0, "in_bounce", -1);
    do_reset(1, "reset_mid_bounce");
    step(1, 0, "idle_after_reset", 60);

    mouse_xpos = 12'd790;
    mouse_ypos = 12'd590;
`ifdef DRAW_RECT_CTL_CLAMP_EN
    step(1, 0, "clamp_corner", 536);
`else
    step(1, 0, "raw_corner", 590);
`endif
    step(0, 1, "press_below_floor", -1);
    step(1, 0, "floor_clamp_stop", 536);
    step(1, 0, "stop_hold_2", 536);

    repeat (3) @(negedge clk40MHz);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
